chicken_turn_ctrl: RTL and testbench

- Game-turn controller that consumes the tile-match result of the tile comparator stage.
- Drives the comparator's load-select line (1 = load edge tile, 0 = load center tile).
- Tracks each chicken's track position and the active player, and decides move, pass or win after every flipped center tile.
- Also produces the edge-tile index the upstream tile memory uses to present edge tile data.

---
 rtl/chicken_turn_ctrl_if.sv | 31 +++
 rtl/chicken_turn_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_chicken_turn_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chicken_turn_ctrl_if.sv
// Flip handshake between the tile comparator / tile memory stage and the turn controller.
//   flip_valid : upstream -> ctrl, a center tile is flipped and held on the comparator input
//   match      : upstream -> ctrl, comparator result (1 = edge tile equals center tile)
//   sel_edge   : ctrl -> upstream, comparator load select (1 = edge, 0 = center)
//   edge_idx   : ctrl -> upstream, edge tile index ahead of the current chicken
//   flip_ack   : ctrl -> upstream, one-cycle pulse, flip has been evaluated
interface chicken_turn_ctrl_if #(
    parameter int unsigned POS_W = 5
) ();
    logic             flip_valid;
    logic             match;
    logic             sel_edge;
    logic [POS_W-1:0] edge_idx;
    logic             flip_ack;

    modport master (
        output flip_valid,
        output match,
        input  sel_edge,
        input  edge_idx,
        input  flip_ack
    );

    modport slave (
        input  flip_valid,
        input  match,
        output sel_edge,
        output edge_idx,
        output flip_ack
    );
endinterface

// File: rtl/chicken_turn_ctrl.sv
// Game-turn controller: sequences the comparator load select for each flipped center
// tile, then moves the current chicken to the next free edge tile on a match or passes
// the turn on a mismatch, and declares a winner once a chicken has looped the track.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   new_game     : one-cycle pulse, restarts the game from any state
//   bus          : flip handshake (slave side), see chicken_turn_ctrl_if
//   cur_player   : active player id
//   pos_flat     : all chicken positions, player i at [i*POS_W +: POS_W]
//   move_pulse   : current chicken advanced
//   pass_pulse   : turn passed to the next player
//   winner_valid : high while the game is won
//   winner_id    : winning player id
module chicken_turn_ctrl #(
    parameter int unsigned N_PLAYERS  = 4,
    parameter int unsigned TRACK_LEN  = 24,
    parameter int unsigned POS_W      = 5,
    parameter int unsigned PLAYER_W   = 2,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_game,
    chicken_turn_ctrl_if.slave         bus,
    output logic [PLAYER_W-1:0]        cur_player,
    output logic [N_PLAYERS*POS_W-1:0] pos_flat,
    output logic                       move_pulse,
    output logic                       pass_pulse,
    output logic                       winner_valid,
    output logic [PLAYER_W-1:0]        winner_id
);

    localparam int unsigned SUM_W   = POS_W + 1;
    localparam int unsigned SPACING = TRACK_LEN / N_PLAYERS;
    localparam int unsigned CNT_W   = $clog2(SETTLE_CYC + 1);

    // One-hot so sel_edge is a single-bit decode of the state register.
    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_LOAD_C = 5'b00010,
        S_EVAL   = 5'b00100,
        S_SETTLE = 5'b01000,
        S_WIN    = 5'b10000
    } state_t;

    typedef logic [N_PLAYERS-1:0][POS_W-1:0] pos_arr_t;
    typedef logic [N_PLAYERS-1:0][SUM_W-1:0] step_arr_t;

    state_t             state;
    logic [CNT_W-1:0]   settle_cnt;
    pos_arr_t           pos;
    step_arr_t          steps;

    logic [POS_W-1:0]   target_c;
    logic [SUM_W-1:0]   dist_c;
    logic [SUM_W-1:0]   step_sum_c;
    logic               found_c;
    logic [POS_W-1:0]   cand_c;
    logic               occ_c;

    // Chickens start evenly spaced around the track.
    function automatic pos_arr_t init_pos();
        pos_arr_t p;
        for (int unsigned i = 0; i < N_PLAYERS; i++) begin
            p[i] = POS_W'(i * SPACING);
        end
        return p;
    endfunction

    function automatic logic [POS_W-1:0] wrap_add(input logic [POS_W-1:0] a, input int unsigned d);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(d);
        if (s >= SUM_W'(TRACK_LEN)) begin
            s = s - SUM_W'(TRACK_LEN);
        end
        return s[POS_W-1:0];
    endfunction

    assign pos_flat     = pos;
    assign bus.sel_edge = (state != S_LOAD_C);

    // First tile ahead of the current chicken not held by any other chicken.
    always_comb begin
        target_c = pos[cur_player];
        dist_c   = '0;
        found_c  = 1'b0;
        cand_c   = '0;
        occ_c    = 1'b0;
        for (int unsigned d = 1; d <= N_PLAYERS; d++) begin
            cand_c = wrap_add(pos[cur_player], d);
            occ_c  = 1'b0;
            for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                if ((PLAYER_W'(p) != cur_player) && (pos[p] == cand_c)) begin
                    occ_c = 1'b1;
                end
            end
            if (!found_c && !occ_c) begin
                found_c  = 1'b1;
                target_c = cand_c;
                dist_c   = SUM_W'(d);
            end
        end
    end

    assign step_sum_c = steps[cur_player] + dist_c;

    // Turn FSM with all game state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_SETTLE;
            settle_cnt   <= CNT_W'(SETTLE_CYC);
            pos          <= init_pos();
            steps        <= '0;
            cur_player   <= '0;
            bus.edge_idx <= POS_W'(1);
            bus.flip_ack <= 1'b0;
            move_pulse   <= 1'b0;
            pass_pulse   <= 1'b0;
            winner_valid <= 1'b0;
            winner_id    <= '0;
        end else if (new_game) begin
            state        <= S_SETTLE;
            settle_cnt   <= CNT_W'(SETTLE_CYC);
            pos          <= init_pos();
            steps        <= '0;
            cur_player   <= '0;
            bus.edge_idx <= POS_W'(1);
            bus.flip_ack <= 1'b0;
            move_pulse   <= 1'b0;
            pass_pulse   <= 1'b0;
            winner_valid <= 1'b0;
            winner_id    <= '0;
        end else begin
            bus.flip_ack <= 1'b0;
            move_pulse   <= 1'b0;
            pass_pulse   <= 1'b0;
            bus.edge_idx <= target_c;
            case (state)
                S_IDLE: begin
                    if (bus.flip_valid) begin
                        state <= S_LOAD_C;
                    end
                end
                S_LOAD_C: begin
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    bus.flip_ack <= 1'b1;
                    settle_cnt   <= CNT_W'(SETTLE_CYC);
                    if (bus.match) begin
                        pos[cur_player]   <= target_c;
                        steps[cur_player] <= step_sum_c;
                        move_pulse        <= 1'b1;
                        if (step_sum_c >= SUM_W'(TRACK_LEN)) begin
                            state        <= S_WIN;
                            winner_valid <= 1'b1;
                            winner_id    <= cur_player;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end else begin
                        cur_player <= (cur_player == PLAYER_W'(N_PLAYERS - 1)) ?
                                      '0 : cur_player + PLAYER_W'(1);
                        pass_pulse <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt <= CNT_W'(1)) begin
                        state <= S_IDLE;
                    end
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                S_WIN: begin
                    state <= S_WIN;
                end
                default: begin
                    state <= S_SETTLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chicken_turn_ctrl.sv
// Directed bench for chicken_turn_ctrl (N_PLAYERS=4, TRACK_LEN=24, SETTLE_CYC=2).
module tb_chicken_turn_ctrl;

    localparam int TRK = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic [1:0]  cur_player;
    logic [19:0] pos_flat;
    logic        move_pulse;
    logic        pass_pulse;
    logic        winner_valid;
    logic [1:0]  winner_id;

    chicken_turn_ctrl_if #(.POS_W(5)) bus ();

    chicken_turn_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .bus          (bus),
        .cur_player   (cur_player),
        .pos_flat     (pos_flat),
        .move_pulse   (move_pulse),
        .pass_pulse   (pass_pulse),
        .winner_valid (winner_valid),
        .winner_id    (winner_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference game state.
    int m_pos[4];
    int m_steps[4];
    int m_cur;
    bit m_won;
    int m_winner;

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) begin
            m_pos[i]   = i * 6;
            m_steps[i] = 0;
        end
        m_cur    = 0;
        m_won    = 1'b0;
        m_winner = 0;
    endfunction

    function automatic int m_target();
        bit occ [TRK];
        for (int t = 0; t < TRK; t++) occ[t] = 1'b0;
        for (int i = 0; i < 4; i++) if (i != m_cur) occ[m_pos[i]] = 1'b1;
        for (int d = 1; d < TRK; d++) begin
            if (!occ[(m_pos[m_cur] + d) % TRK]) return (m_pos[m_cur] + d) % TRK;
        end
        return m_pos[m_cur];
    endfunction

    function automatic logic [19:0] m_flat();
        logic [19:0] f;
        for (int i = 0; i < 4; i++) f[i*5 +: 5] = 5'(m_pos[i]);
        return f;
    endfunction

    // One complete flip with the given comparator result, checked against the model.
    task automatic do_flip(input bit m, input string tag);
        int  exp_t;
        int  exp_d;
        bit  seen;
        exp_t = m_target();
        exp_d = (exp_t - m_pos[m_cur] + TRK) % TRK;
        bus.flip_valid = 1'b1;
        bus.match      = m;
        seen           = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.sel_edge === 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s accept: sel_edge never went low within 30 cycles", tag);
            bus.flip_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus.sel_edge, bus.flip_ack} !== 2'b10) begin
            n_err++;
            $display("FAIL %s eval_cycle: sel_edge,flip_ack got %b want 10", tag, {bus.sel_edge, bus.flip_ack});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus.flip_ack, move_pulse, pass_pulse} !== {1'b1, m, !m}) begin
            n_err++;
            $display("FAIL %s ack: ack,move,pass got %b want %b", tag,
                     {bus.flip_ack, move_pulse, pass_pulse}, {1'b1, m, !m});
        end
        bus.flip_valid = 1'b0;
        if (m) begin
            m_pos[m_cur]   = exp_t;
            m_steps[m_cur] = m_steps[m_cur] + exp_d;
            if (m_steps[m_cur] >= TRK) begin
                m_won    = 1'b1;
                m_winner = m_cur;
            end
        end else begin
            m_cur = (m_cur + 1) % 4;
        end
        n_vec++;
        if (pos_flat !== m_flat()) begin
            n_err++;
            $display("FAIL %s pos_flat: got %h want %h", tag, pos_flat, m_flat());
        end
        n_vec++;
        if (cur_player !== 2'(m_cur)) begin
            n_err++;
            $display("FAIL %s cur_player: got %0d want %0d", tag, cur_player, m_cur);
        end
        n_vec++;
        if (winner_valid !== m_won) begin
            n_err++;
            $display("FAIL %s winner_valid: got %b want %b", tag, winner_valid, m_won);
        end
        if (m_won) begin
            n_vec++;
            if (winner_id !== 2'(m_winner)) begin
                n_err++;
                $display("FAIL %s winner_id: got %0d want %0d", tag, winner_id, m_winner);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus.flip_ack, move_pulse, pass_pulse} !== 3'b000) begin
            n_err++;
            $display("FAIL %s pulse_width: ack,move,pass got %b want 000", tag,
                     {bus.flip_ack, move_pulse, pass_pulse});
        end
        n_vec++;
        if (bus.edge_idx !== 5'(m_target())) begin
            n_err++;
            $display("FAIL %s edge_idx: got %0d want %0d", tag, bus.edge_idx, m_target());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; new_game = 1'b0; bus.flip_valid = 1'b0; bus.match = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (pos_flat !== {5'd18, 5'd12, 5'd6, 5'd0}) begin
            n_err++; $display("FAIL reset pos_flat: got %h want %h", pos_flat, {5'd18, 5'd12, 5'd6, 5'd0});
        end
        n_vec++;
        if ({cur_player, winner_id} !== 4'b0000) begin
            n_err++; $display("FAIL reset ids: cur,winner got %b want 0000", {cur_player, winner_id});
        end
        n_vec++;
        if ({bus.sel_edge, bus.flip_ack, move_pulse, pass_pulse, winner_valid} !== 5'b10000) begin
            n_err++; $display("FAIL reset flags: got %b want 10000",
                              {bus.sel_edge, bus.flip_ack, move_pulse, pass_pulse, winner_valid});
        end
        n_vec++;
        if (bus.edge_idx !== 5'd1) begin
            n_err++; $display("FAIL reset edge_idx: got %0d want 1", bus.edge_idx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_match();
        int cnt;
        bus.flip_valid = 1'b1; bus.match = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (bus.sel_edge !== 1'b0) begin
            n_err++; $display("FAIL match load_c: sel_edge got %b want 0", bus.sel_edge);
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus.sel_edge, bus.flip_ack, move_pulse} !== 3'b100) begin
            n_err++; $display("FAIL match eval: sel,ack,move got %b want 100", {bus.sel_edge, bus.flip_ack, move_pulse});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus.flip_ack, move_pulse, pass_pulse} !== 3'b110) begin
            n_err++; $display("FAIL match ack: ack,move,pass got %b want 110", {bus.flip_ack, move_pulse, pass_pulse});
        end
        n_vec++;
        if (pos_flat !== {5'd18, 5'd12, 5'd6, 5'd1}) begin
            n_err++; $display("FAIL match pos_flat: got %h want %h", pos_flat, {5'd18, 5'd12, 5'd6, 5'd1});
        end
        m_pos[0] = 1; m_steps[0] = 1;
        // Back-to-back: keep flip_valid high, next flip must wait out SETTLE.
        bus.match = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (i == 0) begin
                n_vec++;
                if (bus.edge_idx !== 5'd2) begin
                    n_err++; $display("FAIL match edge_idx: got %0d want 2", bus.edge_idx);
                end
            end
            if (bus.sel_edge === 1'b0) break;
        end
        n_vec++;
        if (cnt !== 3) begin
            n_err++; $display("FAIL back_to_back accept: got %0d cycles want 3", cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.flip_ack, move_pulse, pass_pulse, cur_player} !== 5'b10101) begin
            n_err++; $display("FAIL back_to_back pass: ack,move,pass,cur got %b want 10101",
                              {bus.flip_ack, move_pulse, pass_pulse, cur_player});
        end
        bus.flip_valid = 1'b0;
        m_cur = 1;
    endtask

    task automatic test_mismatch_wrap();
        do_flip(1'b0, "pass_p1");
        do_flip(1'b0, "pass_p2");
        n_vec++;
        if (cur_player !== 2'd3) begin
            n_err++; $display("FAIL wrap pre: cur_player got %0d want 3", cur_player);
        end
        do_flip(1'b0, "pass_wrap");
        n_vec++;
        if ({cur_player, pos_flat} !== {2'd0, 5'd18, 5'd12, 5'd6, 5'd1}) begin
            n_err++; $display("FAIL wrap post: cur,pos got %h want %h", {cur_player, pos_flat},
                              {2'd0, 5'd18, 5'd12, 5'd6, 5'd1});
        end
    endtask

    task automatic test_skip();
        do_flip(1'b0, "skip_pass0");
        repeat (5) do_flip(1'b1, "skip_p1_move");
        repeat (3) do_flip(1'b0, "skip_pass");
        repeat (9) do_flip(1'b1, "skip_p0_move");
        n_vec++;
        if (pos_flat !== {5'd18, 5'd12, 5'd11, 5'd10}) begin
            n_err++; $display("FAIL skip setup: pos_flat got %h want %h", pos_flat, {5'd18, 5'd12, 5'd11, 5'd10});
        end
        do_flip(1'b1, "skip_jump");
        n_vec++;
        if (pos_flat[4:0] !== 5'd13) begin
            n_err++; $display("FAIL skip jump: pos0 got %0d want 13", pos_flat[4:0]);
        end
    endtask

    task automatic test_rst_mid_eval();
        int cnt;
        bus.flip_valid = 1'b1; bus.match = 1'b1;
        cnt = 0;
        while (bus.sel_edge !== 1'b0 && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({pos_flat, cur_player, bus.sel_edge} !== {5'd18, 5'd12, 5'd6, 5'd0, 2'd0, 1'b1}) begin
            n_err++; $display("FAIL rst_mid_eval async: pos,cur,sel got %h", {pos_flat, cur_player, bus.sel_edge});
        end
        bus.flip_valid = 1'b0;
        m_reset();
        @(posedge clk); #1;
        n_vec++;
        if ({bus.flip_ack, move_pulse} !== 2'b00) begin
            n_err++; $display("FAIL rst_mid_eval ack: ack,move got %b want 00", {bus.flip_ack, move_pulse});
        end
        rst = 1'b0;
        bus.flip_valid = 1'b1; bus.match = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.sel_edge === 1'b0) break;
        end
        n_vec++;
        if (cnt !== 3) begin
            n_err++; $display("FAIL rst_mid_eval settle: accept after %0d cycles want 3", cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.flip_ack, pass_pulse, cur_player} !== 4'b1101) begin
            n_err++; $display("FAIL rst_mid_eval pass: ack,pass,cur got %b want 1101", {bus.flip_ack, pass_pulse, cur_player});
        end
        bus.flip_valid = 1'b0;
        m_cur = 1;
    endtask

    task automatic test_win();
        int k;
        repeat (2) do_flip(1'b0, "win_pass");
        repeat (5) do_flip(1'b1, "win_p3_move");
        n_vec++;
        if (pos_flat[19:15] !== 5'd23) begin
            n_err++; $display("FAIL win setup: pos3 got %0d want 23", pos_flat[19:15]);
        end
        do_flip(1'b0, "win_pass3");
        do_flip(1'b1, "win_p0_move");
        repeat (3) do_flip(1'b0, "win_pass");
        do_flip(1'b1, "win_wrap");
        n_vec++;
        if (pos_flat[19:15] !== 5'd0) begin
            n_err++; $display("FAIL win wrap: pos3 got %0d want 0", pos_flat[19:15]);
        end
        k = 0;
        while (!m_won && k < 40) begin
            do_flip(1'b1, "win_run");
            k++;
        end
        n_vec++;
        if ({winner_valid, winner_id, pos_flat[19:15]} !== {1'b1, 2'd3, 5'd18}) begin
            n_err++; $display("FAIL win final: valid,id,pos3 got %b want 11110010",
                              {winner_valid, winner_id, pos_flat[19:15]});
        end
        bus.flip_valid = 1'b1; bus.match = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({bus.sel_edge, bus.flip_ack, move_pulse, winner_valid} !== 4'b1001) begin
                n_err++; $display("FAIL win ignore: sel,ack,move,valid got %b want 1001",
                                  {bus.sel_edge, bus.flip_ack, move_pulse, winner_valid});
            end
        end
        bus.flip_valid = 1'b0;
    endtask

    task automatic test_new_game();
        int cnt;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        m_reset();
        n_vec++;
        if ({winner_valid, winner_id, cur_player, pos_flat} !== {1'b0, 2'd0, 2'd0, 5'd18, 5'd12, 5'd6, 5'd0}) begin
            n_err++; $display("FAIL new_game win: valid,id,cur,pos got %h", {winner_valid, winner_id, cur_player, pos_flat});
        end
        bus.flip_valid = 1'b1; bus.match = 1'b1;
        cnt = 0;
        while (bus.sel_edge !== 1'b0 && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_vec++;
        if (cnt !== 3) begin
            n_err++; $display("FAIL new_game settle: accept after %0d cycles want 3", cnt);
        end
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        bus.flip_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if ({bus.sel_edge, bus.flip_ack, move_pulse, pass_pulse} !== 4'b1000) begin
                n_err++; $display("FAIL new_game load_c: sel,ack,move,pass got %b want 1000",
                                  {bus.sel_edge, bus.flip_ack, move_pulse, pass_pulse});
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (pos_flat !== {5'd18, 5'd12, 5'd6, 5'd0}) begin
            n_err++; $display("FAIL new_game pos: got %h want %h", pos_flat, {5'd18, 5'd12, 5'd6, 5'd0});
        end
        do_flip(1'b1, "restart_move");
        n_vec++;
        if (pos_flat[4:0] !== 5'd1) begin
            n_err++; $display("FAIL new_game restart: pos0 got %0d want 1", pos_flat[4:0]);
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch_wrap();
        test_skip();
        test_rst_mid_eval();
        test_win();
        test_new_game();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
